acx_irq_msi_gen: RTL



---
 rtl/acx_irq_msi_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/acx_irq_msi_gen.sv
// Purpose: turns rising edges on a level interrupt vector into one MSI per edge, round-robin arbitrated.
// Latency: an irq edge sets pending on the next clock, and o_msi_valid rises one clock after that.
// Backpressure: a request is held stable until i_msi_ready. After acceptance an optional holdoff window runs.
//
// Ports:
//   i_clk, i_rstn        clock (rising edge) / asynchronous active-low reset
//   i_irq, i_irq_mask    level interrupt vector / per-bit mask (1 = no MSI)
//   i_msi_en             global enable for starting new requests
//   o_msi_valid/_vector  MSI request handshake with i_msi_ready
//   o_pending            per-bit pending status
//   o_msi_count          free-running 16-bit count of accepted MSIs
module acx_irq_msi_gen #(
  parameter int TGT_DATA_WIDTH = 32,
  parameter int VEC_WIDTH      = 5,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [TGT_DATA_WIDTH-1:0] i_irq,
  input  logic [TGT_DATA_WIDTH-1:0] i_irq_mask,
  input  logic                      i_msi_en,
  output logic                      o_msi_valid,
  input  logic                      i_msi_ready,
  output logic [VEC_WIDTH-1:0]      o_msi_vector,
  output logic [TGT_DATA_WIDTH-1:0] o_pending,
  output logic [15:0]               o_msi_count
);

  // The counter only ever holds HOLDOFF_CYCLES-1 down to 0.
  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;
  localparam bit HAS_HOLDOFF = (HOLDOFF_CYCLES > 0);
  localparam logic [VEC_WIDTH-1:0] LAST_VEC = VEC_WIDTH'(TGT_DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TGT_DATA_WIDTH-1:0] irq_d1;
  logic [TGT_DATA_WIDTH-1:0] irq_rise;
  logic [TGT_DATA_WIDTH-1:0] eligible;
  logic [TGT_DATA_WIDTH-1:0] above_ptr;
  logic [TGT_DATA_WIDTH-1:0] accept_clr;
  logic [TGT_DATA_WIDTH-1:0] pending_d;
  logic [VEC_WIDTH-1:0]      rr_ptr;
  logic [VEC_WIDTH-1:0]      rr_ptr_d;
  logic [VEC_WIDTH-1:0]      arb_vec;
  logic [CNT_W-1:0]          hold_cnt, hold_cnt_d;
  logic                      accept;
  logic                      load_req;

  // Index of the lowest set bit. A zero input returns 0, which is never used
  // because callers check for a nonzero vector first.
  function automatic logic [VEC_WIDTH-1:0] lowest_idx(input logic [TGT_DATA_WIDTH-1:0] v);
    logic [VEC_WIDTH-1:0] idx;
    idx = '0;
    for (int i = TGT_DATA_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = VEC_WIDTH'(i);
    end
    return idx;
  endfunction

  assign irq_rise = i_irq & ~irq_d1;
  assign eligible = o_pending & ~i_irq_mask;

  // Round robin: first look at or above the pointer, then wrap to the bottom.
  assign above_ptr = eligible & ({TGT_DATA_WIDTH{1'b1}} << rr_ptr);
  assign arb_vec   = (|above_ptr) ? lowest_idx(above_ptr) : lowest_idx(eligible);

  assign o_msi_valid = (state_q == ST_REQ);
  assign accept      = o_msi_valid & i_msi_ready;

  // A new edge that arrives in the same cycle as the acceptance wins, so that edge is not lost.
  assign accept_clr = accept ? (TGT_DATA_WIDTH'(1) << o_msi_vector) : '0;
  assign pending_d  = (o_pending & ~accept_clr) | irq_rise;

  assign rr_ptr_d = (o_msi_vector == LAST_VEC) ? '0 : o_msi_vector + VEC_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt;
    load_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_msi_en && (|eligible)) begin
          state_d  = ST_REQ;
          load_req = 1'b1;
        end
      end
      ST_REQ: begin
        // Once a request is raised it is not withdrawn, even if the enable drops or the bit is masked.
        if (i_msi_ready) begin
          if (HAS_HOLDOFF) begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == '0) state_d = ST_IDLE;
        else                hold_cnt_d = hold_cnt - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      irq_d1       <= '0;
      o_pending    <= '0;
      o_msi_vector <= '0;
      rr_ptr       <= '0;
      o_msi_count  <= '0;
    end else begin
      irq_d1    <= i_irq;
      o_pending <= pending_d;
      if (load_req) o_msi_vector <= arb_vec;
      if (accept) begin
        rr_ptr      <= rr_ptr_d;
        o_msi_count <= o_msi_count + 16'd1;
      end
    end
  end

endmodule
